// File: rtl/ram_pkg.sv
// Shared types and helpers for the handshaked dual-port RAM.
// Holds the init/run state encoding, collision-policy constants and even parity.
package ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WRITE_FIRST_C = 1;
    localparam int READ_FIRST_C  = 0;

    // Even parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_dp_hs_if.sv
// Write/read request and response signals of the handshaked dual-port RAM.
// The master drives requests; the slave (the RAM) drives readiness and read results.
interface ram_dp_hs_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              write;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              WriteReady;
    logic              read;
    logic [ADDR_W-1:0] ReadAddr;
    logic              ReadReady;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              ReadErr;
    logic              InitDone;

    modport master (
        output write, WriteAddr, WriteData, read, ReadAddr,
        input  WriteReady, ReadReady, ReadData, ReadValid, ReadErr, InitDone
    );

    modport slave (
        input  write, WriteAddr, WriteData, read, ReadAddr,
        output WriteReady, ReadReady, ReadData, ReadValid, ReadErr, InitDone
    );
endinterface

// File: rtl/ram_core.sv
// Bare storage array with one write port and one registered read port.
// Read data appears one cycle after re; no reset so the array maps onto block RAM.
module ram_core #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    // Same-edge read of a written address returns the old word (read-first).
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_dp_hs.sv
// Dual-port RAM with valid/ready ports, DEPTH-cycle init sweep after reset; RAM_PARITY_EN adds a parity bit per word.
// Read latency READ_LAT (1 or 2) cycles; both ports are not-ready during init and always ready afterwards.
module ram_dp_hs
    import ram_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 4,
    parameter int                DEPTH       = 16,
    parameter int                READ_LAT    = 1,
    parameter int                WRITE_FIRST = WRITE_FIRST_C,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
    input logic        clock,
    input logic        reset,
    ram_dp_hs_if.slave bus
);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("ram_dp_hs: READ_LAT must be 1 or 2");
    end

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        logic              vld;
        logic              err;
        logic [DATA_W-1:0] dat;
    } rd_beat_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              run_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
            run_q    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        run_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.WriteReady = run_q;
    assign bus.ReadReady  = run_q;
    assign bus.InitDone   = run_q;

    logic [MEM_W-1:0] wr_word, init_word, core_wdat, core_rdat;
`ifdef RAM_PARITY_EN
    assign wr_word   = {even_parity(64'(bus.WriteData)), bus.WriteData};
    assign init_word = {even_parity(64'(INIT_VALUE)), INIT_VALUE};
`else
    assign wr_word   = bus.WriteData;
    assign init_word = INIT_VALUE;
`endif

    logic wr_acc, rd_acc, rd_in_range, collide;
    assign wr_acc      = bus.write && run_q && ({1'b0, bus.WriteAddr} < DEPTH_L);
    assign rd_acc      = bus.read && run_q;
    assign rd_in_range = {1'b0, bus.ReadAddr} < DEPTH_L;
    assign collide     = wr_acc && rd_acc && (bus.WriteAddr == bus.ReadAddr);

    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    assign core_we    = (state == INIT) || wr_acc;
    assign core_waddr = (state == INIT) ? init_cnt : bus.WriteAddr;
    assign core_wdat  = (state == INIT) ? init_word : wr_word;

    ram_core #(
        .WORD_W (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clock (clock),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdat),
        .re    (rd_acc && rd_in_range),
        .raddr (bus.ReadAddr),
        .rdata (core_rdat)
    );

    // Side-band for the word the core is fetching: out-of-range and write-first bypass.
    logic             s1_vld, s1_oor, s1_byp;
    logic [MEM_W-1:0] s1_wdat;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_oor  <= 1'b0;
            s1_byp  <= 1'b0;
            s1_wdat <= '0;
        end else begin
            s1_vld <= rd_acc;
            s1_oor <= !rd_in_range;
            s1_byp <= collide && (WRITE_FIRST == WRITE_FIRST_C);
            if (collide) s1_wdat <= wr_word;
        end
    end

    logic [MEM_W-1:0] s1_word;
    logic             par_err;
    assign s1_word = s1_oor ? '0 : (s1_byp ? s1_wdat : core_rdat);
`ifdef RAM_PARITY_EN
    assign par_err = ^s1_word;
`else
    assign par_err = 1'b0;
`endif

    rd_beat_t beat1, beat_in, out_q;
    assign beat1 = '{vld: s1_vld, err: s1_vld && par_err, dat: s1_word[DATA_W-1:0]};

    if (READ_LAT == 2) begin : g_lat2
        rd_beat_t mid_q;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) mid_q <= '0;
            else        mid_q <= beat1;
        end
        assign beat_in = mid_q;
    end else begin : g_lat1
        assign beat_in = beat1;
    end

    // Data only loads on a valid beat so ReadData holds between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q.vld <= beat_in.vld;
            out_q.err <= beat_in.vld && beat_in.err;
            if (beat_in.vld) out_q.dat <= beat_in.dat;
        end
    end

    assign bus.ReadValid = out_q.vld;
    assign bus.ReadErr   = out_q.err;
    assign bus.ReadData  = out_q.dat;

endmodule

// File: tb/tb_ram_dp_hs.sv
// Directed bench for ram_dp_hs: dut_a (16 words, READ_LAT=1, write-first, init A5) and dut_b (12 words, READ_LAT=2, read-first, init 0).
// The parity corruption step is compiled only when RAM_PARITY_EN is defined.
module tb_ram_dp_hs;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mdl [2][16];

    ram_dp_hs_if #(.DATA_W(8), .ADDR_W(4)) ia ();
    ram_dp_hs_if #(.DATA_W(8), .ADDR_W(4)) ib ();

    ram_dp_hs #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .READ_LAT(1), .WRITE_FIRST(1), .INIT_VALUE(8'hA5)
    ) dut_a (
        .clock (clk),
        .reset (reset),
        .bus   (ia)
    );

    ram_dp_hs #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(12), .READ_LAT(2), .WRITE_FIRST(0), .INIT_VALUE(8'h00)
    ) dut_b (
        .clock (clk),
        .reset (reset),
        .bus   (ib)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    function automatic int depth(input int sel);
        return (sel == 0) ? 16 : 12;
    endfunction

    function automatic logic vld_of(input int sel);
        return (sel == 0) ? ia.ReadValid : ib.ReadValid;
    endfunction

    function automatic logic err_of(input int sel);
        return (sel == 0) ? ia.ReadErr : ib.ReadErr;
    endfunction

    function automatic logic [7:0] dat_of(input int sel);
        return (sel == 0) ? ia.ReadData : ib.ReadData;
    endfunction

    task automatic set_rd(input int sel, input logic en, input logic [3:0] a);
        if (sel == 0) begin ia.read = en; ia.ReadAddr = a; end
        else          begin ib.read = en; ib.ReadAddr = a; end
    endtask

    task automatic set_wr(input int sel, input logic en, input logic [3:0] a, input logic [7:0] d);
        if (sel == 0) begin ia.write = en; ia.WriteAddr = a; ia.WriteData = d; end
        else          begin ib.write = en; ib.WriteAddr = a; ib.WriteData = d; end
    endtask

    task automatic do_write(input int sel, input logic [3:0] a, input logic [7:0] d);
        set_wr(sel, 1'b1, a, d);
        cyc();
        set_wr(sel, 1'b0, 4'h0, 8'h00);
        if (int'(a) < depth(sel)) mdl[sel][a] = d;
    endtask

    // Single read, optionally with a same-edge write to the same address.
    task automatic rd_one(input int sel, input logic [3:0] a, input logic [7:0] exp, input logic exp_err,
                          input logic wr_en, input logic [7:0] wd, input string tag);
        set_wr(sel, wr_en, a, wd);
        set_rd(sel, 1'b1, a);
        cyc();
        set_wr(sel, 1'b0, 4'h0, 8'h00);
        set_rd(sel, 1'b0, 4'h0);
        if (wr_en) mdl[sel][a] = wd;
        for (int i = 0; i < lat(sel); i++) begin
            chk1($sformatf("%s_early%0d", tag, i), vld_of(sel), 1'b0);
            cyc();
        end
        chk1({tag, "_vld"}, vld_of(sel), 1'b1);
        chk8({tag, "_dat"}, dat_of(sel), exp);
        chk1({tag, "_err"}, err_of(sel), exp_err);
    endtask

    // Back-to-back reads of addresses 0..n-1; result r is due right after edge r+lat.
    task automatic stream_rd(input int sel, input int n, input string tag);
        int L = lat(sel);
        for (int c = 0; c < n + L; c++) begin
            set_rd(sel, c < n, 4'(c));
            cyc();
            if (c - L >= 0) begin
                chk1($sformatf("%s_vld[%0d]", tag, c - L), vld_of(sel), 1'b1);
                chk8($sformatf("%s_dat[%0d]", tag, c - L), dat_of(sel), mdl[sel][c - L]);
                chk1($sformatf("%s_err[%0d]", tag, c - L), err_of(sel), 1'b0);
            end else begin
                chk1($sformatf("%s_early[%0d]", tag, c), vld_of(sel), 1'b0);
            end
        end
        set_rd(sel, 1'b0, 4'h0);
    endtask

    task automatic init_window(input string tag);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk1($sformatf("%s_a_wrdy[%0d]", tag, k), ia.WriteReady, k >= 16);
            chk1($sformatf("%s_a_rrdy[%0d]", tag, k), ia.ReadReady, k >= 16);
            chk1($sformatf("%s_a_done[%0d]", tag, k), ia.InitDone, k >= 16);
            chk1($sformatf("%s_a_vld[%0d]", tag, k), ia.ReadValid, 1'b0);
            chk1($sformatf("%s_b_rrdy[%0d]", tag, k), ib.ReadReady, k >= 12);
            chk1($sformatf("%s_b_done[%0d]", tag, k), ib.InitDone, k >= 12);
            chk1($sformatf("%s_b_vld[%0d]", tag, k), ib.ReadValid, 1'b0);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) begin
            mdl[0][i] = 8'hA5;
            mdl[1][i] = 8'h00;
        end
    endtask

    initial begin
        set_wr(0, 1'b0, 4'h0, 8'h00);
        set_wr(1, 1'b0, 4'h0, 8'h00);
        set_rd(0, 1'b0, 4'h0);
        set_rd(1, 1'b0, 4'h0);
        reset = 1'b0;
        reset_model();

        #20;
        chk1("rst_a_wrdy", ia.WriteReady, 1'b0);
        chk1("rst_a_rrdy", ia.ReadReady, 1'b0);
        chk1("rst_a_done", ia.InitDone, 1'b0);
        chk1("rst_a_vld", ia.ReadValid, 1'b0);
        chk1("rst_a_err", ia.ReadErr, 1'b0);
        chk8("rst_a_dat", ia.ReadData, 8'h00);
        chk1("rst_b_rrdy", ib.ReadReady, 1'b0);
        chk8("rst_b_dat", ib.ReadData, 8'h00);

        #230 reset = 1'b1;
        init_window("init");

        stream_rd(0, 16, "init_a");
        stream_rd(1, 12, "init_b");

        for (int k = 0; k < 16; k++) do_write(0, 4'(k), 8'(k * 17));
        for (int k = 0; k < 12; k++) do_write(1, 4'(k), 8'(k * 17));
        stream_rd(0, 16, "wr_a");
        stream_rd(1, 12, "wr_b");

        // Collision on address 3 holding 11: write-first sees 22, read-first sees 11.
        do_write(0, 4'd3, 8'h11);
        rd_one(0, 4'd3, 8'h22, 1'b0, 1'b1, 8'h22, "coll_a");
        rd_one(0, 4'd3, 8'h22, 1'b0, 1'b0, 8'h00, "coll_a_next");
        do_write(1, 4'd3, 8'h11);
        rd_one(1, 4'd3, 8'h11, 1'b0, 1'b1, 8'h22, "coll_b");
        rd_one(1, 4'd3, 8'h22, 1'b0, 1'b0, 8'h00, "coll_b_next");

        do_write(1, 4'd13, 8'hFF);
        rd_one(1, 4'd13, 8'h00, 1'b0, 1'b0, 8'h00, "oor_b");
        stream_rd(1, 12, "oor_b_keep");

        // Two reads in flight on dut_b (one on dut_a) when reset hits.
        set_rd(0, 1'b1, 4'd4);
        set_rd(1, 1'b1, 4'd4);
        cyc();
        set_rd(0, 1'b1, 4'd5);
        set_rd(1, 1'b1, 4'd5);
        cyc();
        chk1("mid_a_pre_vld", ia.ReadValid, 1'b1);
        chk8("mid_a_pre_dat", ia.ReadData, 8'h44);
        set_rd(0, 1'b0, 4'h0);
        set_rd(1, 1'b0, 4'h0);
        reset = 1'b0;
        #1;
        chk1("mid_a_vld", ia.ReadValid, 1'b0);
        chk8("mid_a_dat", ia.ReadData, 8'h00);
        chk1("mid_a_rdy", ia.WriteReady, 1'b0);
        chk1("mid_b_vld", ib.ReadValid, 1'b0);
        chk8("mid_b_dat", ib.ReadData, 8'h00);
        chk1("mid_b_rdy", ib.ReadReady, 1'b0);
        cyc();
        reset = 1'b1;
        reset_model();
        set_wr(0, 1'b1, 4'd6, 8'h77);
        set_rd(0, 1'b1, 4'd6);
        init_window("reinit");
        set_wr(0, 1'b0, 4'h0, 8'h00);
        set_rd(0, 1'b0, 4'h0);
        rd_one(0, 4'd6, 8'hA5, 1'b0, 1'b0, 8'h00, "init_ignores_wr");
        stream_rd(0, 16, "reinit_a");
        stream_rd(1, 12, "reinit_b");

`ifdef RAM_PARITY_EN
        do_write(0, 4'd5, 8'h0F);
        dut_a.u_core.mem[5][0] = ~dut_a.u_core.mem[5][0];
        rd_one(0, 4'd5, 8'h0E, 1'b1, 1'b0, 8'h00, "par_bad");
        rd_one(0, 4'd6, 8'hA5, 1'b0, 1'b0, 8'h00, "par_good");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
